// File: rtl/uiup_sample.sv
// 2x nearest-neighbour video upsampler. Input lines land in a ping-pong pair of
// line buffers, and each buffered line is replayed twice with every pixel doubled.
module uiup_sample #(
  parameter int VID_DATA_WIDTH = 16,
  parameter int DST_WIDTH      = 1024,
  parameter int DST_HEIGHT     = 768,
  parameter int H_BLANK        = 32
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic                      I_vid_vs,
  input  logic                      I_vid_de,
  input  logic [VID_DATA_WIDTH-1:0] I_vid_data,
  output logic                      O_vid_vs,
  output logic                      O_vid_de,
  output logic [VID_DATA_WIDTH-1:0] O_vid_data,
  output logic                      O_overflow
);

  localparam int SRC_W  = DST_WIDTH / 2;
  localparam int SRC_H  = DST_HEIGHT / 2;
  localparam int ADDR_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int COL_W  = $clog2(SRC_W) + 1;
  localparam int ROW_W  = $clog2(SRC_H) + 1;
  localparam int PIX_W  = $clog2(DST_WIDTH) + 1;
  localparam int BLK_W  = $clog2(H_BLANK) + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_W - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(SRC_H);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(DST_WIDTH - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(H_BLANK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK
  } state_t;

  state_t                    state_q;
  logic [VID_DATA_WIDTH-1:0] mem_q [2][SRC_W];
  logic [COL_W-1:0]          wr_col_q;
  logic [ROW_W-1:0]          wr_row_q;
  logic [PIX_W-1:0]          pix_q;
  logic [BLK_W-1:0]          blk_q;
  logic                      wr_bank_q;
  logic                      rd_bank_q;
  logic                      pass_q;
  logic                      vs_q;
  logic                      act_q;
  logic                      de_q;
  logic                      ovf_q;
  logic [1:0]                full_q;
  logic [VID_DATA_WIDTH-1:0] rd_data_q;
  logic [VID_DATA_WIDTH-1:0] data_q;

  logic       vs_edge;
  logic       full_clr;
  logic       wr_req;
  logic       wr_en;
  logic       wr_drop;
  logic       wr_last;
  logic [1:0] full_eff;
  logic [1:0] full_d;

  // The read side's end-of-replay clear is applied before the write side looks
  // at the flag, so a pixel arriving in that same cycle is accepted.
  always_comb begin
    vs_edge  = I_vid_vs & ~vs_q;
    full_clr = (state_q == BLANK) && (blk_q == BLK_LAST) && pass_q;
    full_eff = full_q;
    if (full_clr) begin
      full_eff[rd_bank_q] = 1'b0;
    end
    wr_req  = I_vid_de && !vs_edge && (wr_row_q != ROW_END);
    wr_en   = wr_req && !full_eff[wr_bank_q] && !I_rst;
    wr_drop = wr_req && full_eff[wr_bank_q];
    wr_last = wr_en && (wr_col_q == COL_LAST);
    full_d  = full_eff;
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_col_q[ADDR_W-1:0]] <= I_vid_data;
    end
    rd_data_q <= mem_q[rd_bank_q][pix_q[ADDR_W:1]];
  end

  // Output pipeline: ACTIVE -> act_q (read data valid) -> de_q/data_q.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= IDLE;
      wr_col_q  <= '0;
      wr_row_q  <= '0;
      pix_q     <= '0;
      blk_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      pass_q    <= 1'b0;
      vs_q      <= 1'b0;
      act_q     <= 1'b0;
      de_q      <= 1'b0;
      ovf_q     <= 1'b0;
      full_q    <= '0;
      data_q    <= '0;
    end else begin
      vs_q <= I_vid_vs;
      if (vs_edge) begin
        state_q   <= IDLE;
        wr_col_q  <= '0;
        wr_row_q  <= '0;
        wr_bank_q <= 1'b0;
        rd_bank_q <= 1'b0;
        full_q    <= '0;
        act_q     <= 1'b0;
        de_q      <= 1'b0;
      end else begin
        full_q <= full_d;
        if (wr_drop) begin
          ovf_q <= 1'b1;
        end
        if (wr_en) begin
          if (wr_last) begin
            wr_col_q  <= '0;
            wr_bank_q <= ~wr_bank_q;
            wr_row_q  <= wr_row_q + ROW_W'(1);
          end else begin
            wr_col_q <= wr_col_q + COL_W'(1);
          end
        end
        act_q <= (state_q == ACTIVE);
        de_q  <= act_q;
        if (act_q) begin
          data_q <= rd_data_q;
        end
        case (state_q)
          IDLE: begin
            if (full_q[rd_bank_q]) begin
              state_q <= ACTIVE;
              pix_q   <= '0;
              pass_q  <= 1'b0;
            end
          end
          ACTIVE: begin
            if (pix_q == PIX_LAST) begin
              state_q <= BLANK;
              blk_q   <= '0;
            end else begin
              pix_q <= pix_q + PIX_W'(1);
            end
          end
          BLANK: begin
            if (blk_q == BLK_LAST) begin
              if (!pass_q) begin
                pass_q  <= 1'b1;
                pix_q   <= '0;
                state_q <= ACTIVE;
              end else begin
                rd_bank_q <= ~rd_bank_q;
                state_q   <= IDLE;
              end
            end else begin
              blk_q <= blk_q + BLK_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign O_vid_vs   = vs_q;
  assign O_vid_de   = de_q;
  assign O_vid_data = data_q;
  assign O_overflow = ovf_q;

endmodule
